// File: rtl/rop3_pkg.sv
// Shared types and constants for the ROP3 blit sequencer.
// No logic; state encoding and common ROP codes only.
// Imported by the controller and anything that issues commands to it.
package rop3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] ROP_BLACK     = 8'h00;
  localparam logic [7:0] ROP_SRCCOPY   = 8'hCC;
  localparam logic [7:0] ROP_PATCOPY   = 8'hF0;
  localparam logic [7:0] ROP_SRCINVERT = 8'h66;
  localparam logic [7:0] ROP_WHITE     = 8'hFF;

endpackage

// File: rtl/rop3_blit_ctrl_if.sv
// Command, operand, ROP-unit and result signals of the blit sequencer.
// Pure wiring; no latency.
// slave = sequencer side, master = fetch engine / writeback / ROP unit side.
interface rop3_blit_ctrl_if #(
  parameter int N     = 6,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic             src_valid;
  logic             src_ready;
  logic [N-1:0]     src_p;
  logic [N-1:0]     src_s;
  logic [N-1:0]     src_d;
  logic [N-1:0]     rop_p;
  logic [N-1:0]     rop_s;
  logic [N-1:0]     rop_d;
  logic [7:0]       rop_mode;
  logic [N-1:0]     rop_result;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic             res_last;
  logic             busy;
  logic             done;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len, src_valid, src_p, src_s, src_d,
           rop_result, res_ready,
    output cmd_ready, src_ready, rop_p, rop_s, rop_d, rop_mode,
           res_valid, res_data, res_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_len, src_valid, src_p, src_s, src_d,
           rop_result, res_ready,
    input  cmd_ready, src_ready, rop_p, rop_s, rop_d, rop_mode,
           res_valid, res_data, res_last, busy, done
  );
endinterface

// File: rtl/rop3_ctrl_fifo.sv
// Small synchronous FIFO holding ROP results plus their last-beat flag.
// Write-to-read latency 1 cycle; head entry is held in the storage registers.
// No internal backpressure: the caller's credit scheme guarantees no overflow; push+pop when full is legal.
module rop3_ctrl_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 3,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          vld,
  output logic [CW-1:0] cnt
);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PONE;
  endfunction

  // Storage write; contents need no reset since cnt gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CONE;
        2'b01:   cnt <= cnt - CONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
  assign vld  = (cnt != '0);
endmodule

// File: rtl/rop3_blit_ctrl.sv
// Burst sequencer feeding one ROP3 unit and queueing its results for writeback.
// Result appears LAT+1 cycles after operand accept; sustains 1 pixel/cycle when unstalled.
// Operand issue is credit-limited (queued + in-flight < LAT+2) so output stalls never drop results.
module rop3_blit_ctrl
  import rop3_pkg::*;
#(
  parameter int N     = 6,
  parameter int LEN_W = 8,
  parameter int LAT   = 1
) (
  input logic             clk,
  input logic             rst,
  rop3_blit_ctrl_if.slave bus
);
  localparam int DEPTH = LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
  localparam logic [CW-1:0]    CONE = CW'(1);

  state_t           state, state_nx;
  logic [LEN_W-1:0] len_r, issued, popped;
  logic [7:0]       mode_r;
  logic [LAT-1:0]   tags, lasts;
  logic [CW-1:0]    inflight, fifo_cnt;
  logic [CW:0]      credit_sum;
  logic             credit_ok, cmd_fire, fire, pop, tag_out;
  logic             last_issue, last_pop;
  logic             cmd_ready, src_ready, done;
  logic [N:0]       fifo_dout;
  logic             fifo_vld;

  assign cmd_fire   = bus.cmd_valid & cmd_ready;
  assign fire       = bus.src_valid & src_ready;
  assign pop        = fifo_vld & bus.res_ready;
  assign tag_out    = tags[LAT-1];
  assign last_issue = (issued + ONE == len_r);
  assign last_pop   = (popped + ONE == len_r);
  // A pop in the same cycle is deliberately not credited back.
  assign credit_sum = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign credit_ok  = credit_sum < (CW + 1)'(DEPTH);

  // Next-state and handshake decode.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    src_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nx = (bus.cmd_len == '0) ? DONE : RUN;
      end
      RUN: begin
        src_ready = credit_ok;
        if (fire && last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && last_pop) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, command latch, beat counters and in-flight tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_r    <= '0;
      mode_r   <= '0;
      issued   <= '0;
      popped   <= '0;
      tags     <= '0;
      lasts    <= '0;
      inflight <= '0;
    end else begin
      state <= state_nx;
      if (cmd_fire) begin
        len_r  <= bus.cmd_len;
        mode_r <= bus.cmd_mode;
        issued <= '0;
        popped <= '0;
      end else begin
        if (fire) issued <= issued + ONE;
        if (pop)  popped <= popped + ONE;
      end
      tags  <= (tags << 1)  | LAT'(fire);
      lasts <= (lasts << 1) | LAT'(fire & last_issue);
      case ({fire, tag_out})
        2'b10:   inflight <= inflight + CONE;
        2'b01:   inflight <= inflight - CONE;
        default: inflight <= inflight;
      endcase
    end
  end

  rop3_ctrl_fifo #(.W(N + 1), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tag_out),
    .din  ({lasts[LAT-1], bus.rop_result}),
    .pop  (pop),
    .dout (fifo_dout),
    .vld  (fifo_vld),
    .cnt  (fifo_cnt)
  );

  assign bus.cmd_ready = cmd_ready;
  assign bus.src_ready = src_ready;
  assign bus.rop_p     = bus.src_p;
  assign bus.rop_s     = bus.src_s;
  assign bus.rop_d     = bus.src_d;
  assign bus.rop_mode  = mode_r;
  assign bus.res_valid = fifo_vld;
  assign bus.res_data  = fifo_dout[N-1:0];
  assign bus.res_last  = fifo_vld & fifo_dout[N];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
endmodule

// File: tb/tb_rop3_blit_ctrl.sv
// Self-checking bench for rop3_blit_ctrl with a behavioural ROP3 unit (LAT=1).
// A monitor logs handshakes and scores results against a queue of expected pixels.
// Scenario tasks drive commands/operands and compare what the monitor recorded.
module tb_rop3_blit_ctrl;
  import rop3_pkg::*;

  localparam int N     = 6;
  localparam int LEN_W = 8;
  localparam int LAT   = 1;
  localparam int DEPTH = LAT + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rop3_blit_ctrl_if #(.N(N), .LEN_W(LEN_W)) bus ();
  rop3_blit_ctrl #(.N(N), .LEN_W(LEN_W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Operand source table, stimulus rates
  logic [3*N-1:0] ops [65536];
  int ops_n   = 0;
  int src_pct = 100;
  int res_pct = 100;

  // Monitor records
  int cyc = 0, fire_cnt = 0, pop_cnt = 0, done_cnt = 0, cmd_cnt = 0;
  int sb_bad = 0, idle_src_bad = 0, mode_bad = 0;
  logic [N:0] obs [65536];
  int obs_cyc [65536];
  int cmd_cycs [4096];
  int done_cycs [4096];
  logic [N:0] exp_q [$];
  logic [7:0] cur_mode = 8'h00;
  int cur_len = 0, beat_idx = 0;

  // ROP3 truth table: each result bit selects mode bit {P,S,D}.
  function automatic logic [N-1:0] rop3(input logic [7:0] m, input logic [N-1:0] p,
                                        input logic [N-1:0] s, input logic [N-1:0] d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m[{p[i], s[i], d[i]}];
    return r;
  endfunction

  // Behavioural ROP3 unit: one-cycle registered result.
  always @(posedge clk) bus.rop_result <= rop3(bus.rop_mode, bus.rop_p, bus.rop_s, bus.rop_d);

  // Operand/result-side driver with random gaps.
  always @(posedge clk) begin
    #1;
    if (fire_cnt < ops_n && $urandom_range(0, 99) < src_pct) begin
      bus.src_valid = 1'b1;
      {bus.src_p, bus.src_s, bus.src_d} = ops[16'(fire_cnt)];
    end else begin
      bus.src_valid = 1'b0;
      {bus.src_p, bus.src_s, bus.src_d} = 18'($urandom);
    end
    bus.res_ready = ($urandom_range(0, 99) < res_pct);
  end

  // Monitor and scoreboard bookkeeping.
  always @(negedge clk) begin
    logic [N:0] got, want;
    cyc++;
    if (rst) begin
      exp_q.delete();
      beat_idx = 0;
    end else begin
      if (bus.busy && bus.rop_mode !== cur_mode) mode_bad++;
      if (bus.src_ready && (!bus.busy || bus.done)) idle_src_bad++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        cur_mode = bus.cmd_mode;
        cur_len  = int'(bus.cmd_len);
        beat_idx = 0;
        cmd_cycs[12'(cmd_cnt)] = cyc;
        cmd_cnt++;
      end
      if (bus.src_valid && bus.src_ready) begin
        exp_q.push_back({(beat_idx == cur_len - 1), rop3(cur_mode, bus.src_p, bus.src_s, bus.src_d)});
        beat_idx++;
        fire_cnt++;
      end
      if (bus.res_valid && bus.res_ready) begin
        got = {bus.res_last, bus.res_data};
        obs[16'(pop_cnt)] = got;
        obs_cyc[16'(pop_cnt)] = cyc;
        pop_cnt++;
        if (exp_q.size() == 0) sb_bad++;
        else begin
          want = exp_q.pop_front();
          if (want !== got) sb_bad++;
        end
      end
      if (bus.done) begin
        done_cycs[12'(done_cnt)] = cyc;
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic nsample();
    @(negedge clk); #1;
  endtask

  task automatic add_op(input logic [N-1:0] p, input logic [N-1:0] s, input logic [N-1:0] d);
    ops[16'(ops_n)] = {p, s, d};
    ops_n++;
  endtask

  task automatic send_cmd(input logic [7:0] m, input int len, output bit ok);
    ok = 1'b0;
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_len   = LEN_W'(len);
    for (int i = 0; i < 6000 && !ok; i++) begin
      nsample();
      if (bus.cmd_ready) ok = 1'b1;
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      nsample();
      if (done_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) nsample();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    checks++; if (bus.src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready got %b want 0", bus.src_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    checks++; if (bus.res_last !== 1'b0) begin errors++; $display("FAIL reset_res_last got %b want 0", bus.res_last); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.rop_mode !== 8'h00) begin errors++; $display("FAIL reset_rop_mode got %h want 00", bus.rop_mode); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_srccopy();
    int base, d0; bit ok;
    base = pop_cnt; d0 = done_cnt;
    src_pct = 100; res_pct = 100;
    for (int i = 1; i <= 4; i++) add_op(N'($urandom), N'(i), N'($urandom));
    send_cmd(ROP_SRCCOPY, 4, ok);
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL srccopy_done timeout got %0d dones want %0d", done_cnt - d0, 1); end
    checks++; if (pop_cnt - base != 4) begin errors++; $display("FAIL srccopy_count got %0d want 4", pop_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs[16'(base + i)] !== {(i == 3), N'(i + 1)}) begin
        errors++; $display("FAIL srccopy_beat%0d got %h want %h", i, obs[16'(base + i)], {(i == 3), N'(i + 1)});
      end
    end
    checks++; if (obs_cyc[16'(base + 3)] - obs_cyc[16'(base)] != 3) begin
      errors++; $display("FAIL srccopy_rate got %0d cycles for 4 beats want 3", obs_cyc[16'(base + 3)] - obs_cyc[16'(base)]);
    end
    checks++; if (done_cycs[12'(d0)] != obs_cyc[16'(base + 3)] + 1) begin
      errors++; $display("FAIL srccopy_done_cycle got %0d want %0d", done_cycs[12'(d0)], obs_cyc[16'(base + 3)] + 1);
    end
  endtask

  task automatic test_stall();
    int base, d0, f0; bit ok;
    logic [N:0] want [3];
    want[0] = {1'b0, 6'h30}; want[1] = {1'b0, 6'h0F}; want[2] = {1'b1, 6'h00};
    base = pop_cnt; d0 = done_cnt; f0 = fire_cnt;
    res_pct = 0;
    add_op(6'h00, 6'h3F, 6'h0F); add_op(6'h00, 6'h3F, 6'h30); add_op(6'h00, 6'h3F, 6'h3F);
    send_cmd(ROP_SRCINVERT, 3, ok);
    repeat (10) nsample();
    checks++; if (fire_cnt - f0 != DEPTH) begin errors++; $display("FAIL stall_issued got %0d want %0d", fire_cnt - f0, DEPTH); end
    checks++; if (bus.src_ready !== 1'b0) begin errors++; $display("FAIL stall_src_ready got %b want 0", bus.src_ready); end
    checks++; if (pop_cnt != base || bus.res_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold got pops=%0d valid=%b want pops=0 valid=1", pop_cnt - base, bus.res_valid);
    end
    res_pct = 100;
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok || pop_cnt - base != 3) begin errors++; $display("FAIL stall_count got %0d want 3", pop_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[16'(base + i)] !== want[i]) begin
        errors++; $display("FAIL stall_beat%0d got %h want %h", i, obs[16'(base + i)], want[i]);
      end
    end
  endtask

  task automatic test_credit();
    int base, d0, f0, s0; bit ok;
    base = pop_cnt; d0 = done_cnt; f0 = fire_cnt; s0 = sb_bad;
    res_pct = 0;
    for (int i = 0; i < 6; i++) add_op(N'($urandom), N'($urandom), N'($urandom));
    send_cmd(ROP_SRCCOPY, 6, ok);
    repeat (10) nsample();
    checks++; if (fire_cnt - f0 != DEPTH) begin errors++; $display("FAIL credit_issued got %0d want %0d", fire_cnt - f0, DEPTH); end
    res_pct = 100;
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok || pop_cnt - base != 6 || sb_bad != s0) begin
      errors++; $display("FAIL credit_results got pops=%0d bad=%0d want pops=6 bad=0", pop_cnt - base, sb_bad - s0);
    end
  endtask

  task automatic test_len_zero();
    int base, d0, f0, c0; bit ok;
    base = pop_cnt; d0 = done_cnt; f0 = fire_cnt; c0 = cmd_cnt;
    send_cmd(ROP_WHITE, 0, ok);
    wait_done(d0 + 1, 50, ok);
    checks++; if (!ok || done_cycs[12'(d0)] != cmd_cycs[12'(c0)] + 1) begin
      errors++; $display("FAIL len0_done_cycle got %0d want %0d", done_cycs[12'(d0)], cmd_cycs[12'(c0)] + 1);
    end
    nsample();
    checks++; if (fire_cnt != f0 || pop_cnt != base) begin
      errors++; $display("FAIL len0_traffic got fires=%0d pops=%0d want 0 0", fire_cnt - f0, pop_cnt - base);
    end
    checks++; if (bus.rop_mode !== ROP_WHITE) begin errors++; $display("FAIL len0_rop_mode got %h want ff", bus.rop_mode); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL len0_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int base, d0, c0, m0; bit ok1, ok2, ok;
    logic [N-1:0] p0, p1;
    base = pop_cnt; d0 = done_cnt; c0 = cmd_cnt; m0 = mode_bad;
    p0 = N'($urandom); p1 = N'($urandom);
    add_op(p0, N'($urandom), N'($urandom)); add_op(p1, N'($urandom), N'($urandom));
    add_op(N'($urandom), N'($urandom), N'($urandom)); add_op(N'($urandom), N'($urandom), N'($urandom));
    send_cmd(ROP_PATCOPY, 2, ok1);
    send_cmd(ROP_BLACK, 2, ok2);
    wait_done(d0 + 2, 200, ok);
    checks++; if (!(ok1 && ok2 && ok)) begin errors++; $display("FAIL b2b_timeout got %0b%0b%0b want 111", ok1, ok2, ok); end
    checks++; if (cmd_cycs[12'(c0 + 1)] != done_cycs[12'(d0)] + 1) begin
      errors++; $display("FAIL b2b_accept_cycle got %0d want %0d", cmd_cycs[12'(c0 + 1)], done_cycs[12'(d0)] + 1);
    end
    checks++; if (obs[16'(base)] !== {1'b0, p0} || obs[16'(base + 1)] !== {1'b1, p1}) begin
      errors++; $display("FAIL b2b_patcopy got %h %h want %h %h", obs[16'(base)], obs[16'(base + 1)], {1'b0, p0}, {1'b1, p1});
    end
    checks++; if (obs[16'(base + 2)] !== 7'h00 || obs[16'(base + 3)] !== 7'h40) begin
      errors++; $display("FAIL b2b_black got %h %h want 00 40", obs[16'(base + 2)], obs[16'(base + 3)]);
    end
    checks++; if (mode_bad != m0) begin errors++; $display("FAIL b2b_mode_stable got %0d changes want 0", mode_bad - m0); end
  endtask

  task automatic test_mid_reset();
    int base, d0, f0, s0; bit ok;
    base = pop_cnt; f0 = fire_cnt;
    src_pct = 100; res_pct = 0;
    for (int i = 0; i < 8; i++) add_op(N'($urandom), N'($urandom), N'($urandom));
    send_cmd(ROP_SRCCOPY, 8, ok);
    for (int i = 0; i < 100 && fire_cnt - f0 < 3; i++) nsample();
    tick();
    rst = 1'b1; src_pct = 0;
    nsample();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.src_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_last !== 1'b0) begin
      errors++; $display("FAIL midrst_handshake got cr=%b sr=%b rv=%b rl=%b want 1 0 0 0", bus.cmd_ready, bus.src_ready, bus.res_valid, bus.res_last);
    end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rop_mode !== 8'h00) begin
      errors++; $display("FAIL midrst_state got busy=%b done=%b mode=%h want 0 0 00", bus.busy, bus.done, bus.rop_mode);
    end
    tick();
    rst = 1'b0;
    ops_n = fire_cnt;
    base = pop_cnt; d0 = done_cnt; s0 = sb_bad;
    add_op(N'($urandom), 6'h15, N'($urandom));
    src_pct = 100; res_pct = 100;
    send_cmd(ROP_SRCCOPY, 1, ok);
    wait_done(d0 + 1, 100, ok);
    repeat (3) nsample();
    checks++; if (!ok || pop_cnt - base != 1) begin errors++; $display("FAIL midrst_count got %0d want 1", pop_cnt - base); end
    checks++; if (obs[16'(base)] !== {1'b1, 6'h15} || sb_bad != s0) begin
      errors++; $display("FAIL midrst_beat got %h want 55", obs[16'(base)]);
    end
  endtask

  task automatic test_random();
    int base, d0, f0, s0, total, tmo, len;
    bit ok;
    logic [7:0] m;
    base = pop_cnt; d0 = done_cnt; f0 = fire_cnt; s0 = sb_bad;
    total = 0; tmo = 0;
    for (int c = 0; c < 2000; c++) begin
      m = 8'($urandom);
      len = (c == 0) ? 255 : int'($urandom_range(0, 12));
      for (int i = 0; i < len; i++) add_op(N'($urandom), N'($urandom), N'($urandom));
      total += len;
      if (c % 16 == 0) begin
        src_pct = int'($urandom_range(40, 100));
        res_pct = int'($urandom_range(40, 100));
      end
      send_cmd(m, len, ok);
      if (!ok) tmo++;
    end
    wait_done(d0 + 2000, 20000, ok);
    checks++; if (tmo != 0 || !ok) begin errors++; $display("FAIL rand_timeout got %0d stuck cmds done_ok=%0b want 0 1", tmo, ok); end
    checks++; if (done_cnt - d0 != 2000) begin errors++; $display("FAIL rand_done_count got %0d want 2000", done_cnt - d0); end
    checks++; if (fire_cnt - f0 != total) begin errors++; $display("FAIL rand_issued got %0d want %0d", fire_cnt - f0, total); end
    checks++; if (pop_cnt - base != total) begin errors++; $display("FAIL rand_results got %0d want %0d", pop_cnt - base, total); end
    checks++; if (sb_bad != s0) begin errors++; $display("FAIL rand_scoreboard got %0d bad beats want 0", sb_bad - s0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d pending want 0", exp_q.size()); end
    checks++; if (idle_src_bad != 0 || mode_bad != 0) begin
      errors++; $display("FAIL rand_protocol got idle_src=%0d mode_changes=%0d want 0 0", idle_src_bad, mode_bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 8'h00;
    bus.cmd_len   = '0;
    bus.src_valid = 1'b0;
    bus.src_p = '0; bus.src_s = '0; bus.src_d = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_srccopy();
    test_stall();
    test_credit();
    test_len_zero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #980000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
